mips_dmem_responder: RTL
========================

Name: mips_dmem_responder

Overview:
- Memory-side responder for the core's data port (mem_ren/mem_wen/mem_addr/mem_dout in, mem_din out).
- Word-addressed backing RAM with slow, multi-cycle writes, fronted by a posted write buffer.
- Reads forward from the write buffer, so the core sees its own writes immediately.
- Asserts mem_stall when the buffer cannot accept a write; the core holds the request while stalled.

Parameters:
ADDR_WIDTH, 10, word-index width; RAM depth 2^ADDR_WIDTH words
WB_DEPTH, 4, write-buffer entries (power of 2, >=2)
WR_LAT, 3, cycles per backing-RAM write (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
mem_ren  input  1  read request from core
mem_wen  input  1  write request from core
mem_addr  input  32  byte address; word index = mem_addr[ADDR_WIDTH+1:2]
mem_dout  input  32  write data from core
mem_din  output  32  read data to core
mem_stall  output  1  write not accepted this cycle
wb_empty  output  1  write buffer empty and drain FSM idle

Behaviour:
- Addressing: bits above ADDR_WIDTH+1 are ignored (index wraps). mem_addr[1:0] is ignored unless the optional feature is enabled.
- Read, combinational, zero latency:
  - mem_ren=0: mem_din=0.
  - Otherwise mem_din = data of the youngest buffer entry whose index matches, including the entry currently being drained.
  - With no match: mem_din = RAM[index].
  - A write presented in the same cycle is not visible until after the next edge.
- Write accept: accepted at the edge when mem_wen=1 and count<WB_DEPTH; entry {index,data} is pushed at the tail.
- mem_stall = mem_wen & (count==WB_DEPTH), combinational. There is no bypass: a pop in the same cycle does not clear the stall.
- Drain FSM, states IDLE and WRITE:
  - IDLE: if count>0, go to WRITE and load lat_cnt=WR_LAT-1.
  - WRITE: if lat_cnt>0, decrement. If lat_cnt==0: write RAM[head.index]<=head.data, pop head, advance head pointer.
  - After the pop: go to IDLE if the resulting count (including any same-cycle push) is 0; otherwise stay in WRITE and reload lat_cnt.
  - Result: one entry retires every WR_LAT cycles while busy, plus one IDLE cycle after each empty period.
- Simultaneous push and pop: count unchanged; pointers wrap modulo WB_DEPTH.
- Same-index writes stay in FIFO order; the RAM ends with the last-written value.
- mem_ren and mem_wen in the same cycle: both are honoured independently.
- wb_empty = (count==0) & (state==IDLE).
- Reset (asynchronous, while rst=0):
  - count=0, pointers=0, state=IDLE, lat_cnt=0.
  - Pending writes are discarded, including one mid-drain.
  - RAM contents are not reset.
  - Outputs: mem_din=0, mem_stall=0, wb_empty=1.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - Extra output port misalign_err (1 bit).
  - Set sticky when mem_ren or mem_wen is asserted with mem_addr[1:0]!=0; cleared only by reset.
  - Misaligned writes are dropped: never pushed, no stall.
  - Misaligned reads return mem_din=0.
- Undefined: no port; mem_addr[1:0] is ignored and all accesses are treated as aligned.

Test Plan:
- Reset: hold rst=0 mid-drain with 3 entries queued -> mem_stall=0, wb_empty=1, mem_din=0; after release, a read of those addresses returns the old RAM values.
- Forwarding: write 0x11223344 to 0x40, read 0x40 the next cycle -> mem_din=0x11223344 while wb_empty=0; with WR_LAT=3 and the buffer otherwise empty, wb_empty=1 exactly 4 cycles after the accepting edge.
- Same-index ordering: write 0xA to 0x80, then 0xB to 0x80 -> a read returns 0xB throughout the drain; after wb_empty=1, RAM[0x20]=0xB.
- Full/stall: 5 back-to-back writes with WB_DEPTH=4, WR_LAT=3 -> mem_stall=1 on the 5th until the first pop; the 5th is accepted on the first cycle with count<4, and the final RAM holds all 5 values.
- Wrap and dual access: write 0xCAFE to 0x1000 (index 0 with ADDR_WIDTH=10) while reading 0x0 in the same cycle -> the same-cycle read returns the old value, the next-cycle read returns 0xCAFE.
- DMEM_ALIGN_CHECK_EN: write to 0x42 -> misalign_err=1 and stays 1, no entry pushed (wb_empty stays 1); a read of 0x41 returns 0.

Source files
------------

// File: rtl/mips_dmem_responder_if.sv
// Core data-port bus between the core (master) and the data-memory responder (slave).
interface mips_dmem_responder_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        wb_empty;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, wb_empty
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, wb_empty
  );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: slow word RAM behind a posted, forwarding write buffer.
// Optional DMEM_ALIGN_CHECK_EN adds a sticky misalign_err output and drops misaligned accesses.
module mips_dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int WB_DEPTH   = 4,
  parameter int WR_LAT     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  mips_dmem_responder_if.slave  bus
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WB_DEPTH);
  localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(WR_LAT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;

  logic [ADDR_WIDTH-1:0]  wb_idx_mem  [WB_DEPTH];
  logic [31:0]            wb_data_mem [WB_DEPTH];
  logic [31:0]            ram_mem     [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0]  idx;
  logic                   aligned;
  logic                   wen_ok;
  logic                   push;
  logic                   pop;
  logic [CNT_W-1:0]       count_after;
  logic                   fwd_hit;
  logic [31:0]            fwd_data;
  logic [PTR_W-1:0]       slot;
  logic [31:0]            rd_data;

  assign idx = bus.mem_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  logic unused_addr;

  assign aligned     = (bus.mem_addr[1:0] == 2'b00);
  assign unused_addr = ^bus.mem_addr[31:ADDR_WIDTH+2];

  always_comb begin
    misalign_d = misalign_q | ((bus.mem_ren | bus.mem_wen) & ~aligned);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end

  assign misalign_err = misalign_q;
`else
  logic unused_addr;

  assign aligned     = 1'b1;
  assign unused_addr = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[1:0]};
`endif

  assign wen_ok = bus.mem_wen & aligned;
  // No bypass: a full buffer stalls even if the head retires this same cycle.
  assign push   = wen_ok & (count_q != CNT_FULL);
  assign pop    = (state_q == S_WRITE) && (lat_q == '0);

  always_comb begin
    count_after = count_q + CNT_W'(push) - CNT_W'(pop);
    count_d     = count_after;
    head_d      = head_q + PTR_W'(pop);
    tail_d      = tail_q + PTR_W'(push);
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_WRITE;
          lat_d   = LAT_RELOAD;
        end
      end
      S_WRITE: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end else if (count_after == '0) begin
          state_d = S_IDLE;
        end else begin
          lat_d = LAT_RELOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
        lat_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage and RAM carry no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_idx_mem[tail_q]  <= idx;
      wb_data_mem[tail_q] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) ram_mem[wb_idx_mem[head_q]] <= wb_data_mem[head_q];
  end

  // Scan oldest to youngest so the last match is the most recent write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    slot     = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (wb_idx_mem[slot] == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_mem[slot];
      end
    end
    rd_data = fwd_hit ? fwd_data : ram_mem[idx];
  end

  assign bus.mem_din   = (rst && bus.mem_ren && aligned) ? rd_data : 32'h0;
  assign bus.mem_stall = wen_ok & (count_q == CNT_FULL);
  assign bus.wb_empty  = (count_q == '0) && (state_q == S_IDLE);

endmodule
